// File: rtl/trace_display_scan.sv
// trace_display_scan: 8-digit multiplexed hex display of an ALU result (NumberA)
// and PC (NumberB), with an optional 8-entry step history that can be scrolled.
// Build option: define TRACE_HISTORY_EN to include the history ring and
// Prev/Next scrolling. Without it, the display is always live and
// Offset/Count read 0.
module trace_display_scan #(
    parameter int REFRESH_CYCLES = 100000,
    parameter int DEPTH          = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        StepTick,
    input  logic [31:0] NumberA,
    input  logic [31:0] NumberB,
    input  logic        Prev,
    input  logic        Next,
    output logic [6:0]  out7,
    output logic [7:0]  en_out,
    output logic [3:0]  Offset,
    output logic [3:0]  Count
);

    localparam int DIV_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_CYCLES - 1);

    // Only the low 16 bits of each number are ever shown.
    logic        unused_hi;
    assign unused_hi = ^{NumberA[31:16], NumberB[31:16]};

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic             started_q, started_d;
    logic             wrap;
    logic [31:0]      live_q;     // {NumberB[15:0], NumberA[15:0]}
    logic [31:0]      view;       // same layout, selected source
    logic [3:0]       nib;
    logic [6:0]       out7_q, out7_d;
    logic [7:0]       en_q, en_d;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    endfunction

`ifdef TRACE_HISTORY_EN
    logic [31:0] ring_q [DEPTH];
    logic [2:0]  wr_q;
    logic [3:0]  off_q, off_d, cnt_q, cnt_d;
    logic [4:0]  off_tmp;

    // Count saturates at DEPTH; Offset tracks captures so the viewed entry
    // stays put, then clamps to the number of valid entries.
    always_comb begin
        cnt_d   = cnt_q;
        off_tmp = 5'd0;
        if (StepTick && cnt_q != 4'(DEPTH))
            cnt_d = cnt_q + 4'd1;
        off_tmp = {1'b0, off_q}
                + 5'(StepTick && off_q != 4'd0)
                + 5'(Prev && !Next);
        if (Next && !Prev && off_tmp != 5'd0)
            off_tmp = off_tmp - 5'd1;
        off_d = (off_tmp > {1'b0, cnt_d}) ? cnt_d : off_tmp[3:0];
    end

    // History pointers and counters.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_q  <= 3'd0;
            cnt_q <= 4'd0;
            off_q <= 4'd0;
        end else begin
            if (StepTick)
                wr_q <= wr_q + 3'd1;
            cnt_q <= cnt_d;
            off_q <= off_d;
        end
    end

    // Ring storage needs no reset; unwritten slots are never reachable.
    always_ff @(posedge Clk) begin
        if (StepTick && !Rst)
            ring_q[wr_q] <= {NumberB[15:0], NumberA[15:0]};
    end

    // At Offset=8 the index wraps onto wr_q, i.e. the oldest entry.
    assign view   = (off_q == 4'd0) ? live_q : ring_q[wr_q - off_q[2:0]];
    assign Offset = off_q;
    assign Count  = cnt_q;
`else
    localparam int unused_depth = DEPTH;
    logic unused_hist;
    assign unused_hist = ^{StepTick, Prev, Next};

    assign view   = live_q;
    assign Offset = 4'd0;
    assign Count  = 4'd0;
`endif

    // Scan divider, digit index and the registered segment/enable outputs.
    // The first wrap only starts scanning at digit 0; later wraps advance it.
    always_comb begin
        wrap      = (div_q == DIV_LAST);
        div_d     = wrap ? '0 : div_q + DIV_W'(1);
        started_d = started_q | wrap;
        idx_d     = (wrap && started_q) ? idx_q + 3'd1 : idx_q;
        nib       = view[{idx_d, 2'b00} +: 4];
        en_d      = started_d ? ~(8'b1 << idx_d) : 8'hFF;
        out7_d    = started_d ? hex_seg(nib) : 7'h7F;
    end

    // Display state registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            div_q     <= '0;
            idx_q     <= 3'd0;
            started_q <= 1'b0;
            live_q    <= 32'd0;
            en_q      <= 8'hFF;
            out7_q    <= 7'h7F;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            started_q <= started_d;
            live_q    <= {NumberB[15:0], NumberA[15:0]};
            en_q      <= en_d;
            out7_q    <= out7_d;
        end
    end

    assign out7   = out7_q;
    assign en_out = en_q;

endmodule

// File: tb/tb_trace_display_scan.sv
// Directed bench for trace_display_scan with REFRESH_CYCLES=4.
// Expectations cover both builds (TRACE_HISTORY_EN defined or not).
module tb_trace_display_scan;

`ifdef TRACE_HISTORY_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        StepTick = 1'b0;
    logic [31:0] NumberA = 32'h0000_A1F8;
    logic [31:0] NumberB = 32'h0;
    logic        Prev = 1'b0;
    logic        Next = 1'b0;
    logic [6:0]  out7;
    logic [7:0]  en_out;
    logic [3:0]  Offset;
    logic [3:0]  Count;

    int total = 0;
    int bad   = 0;

    trace_display_scan #(.REFRESH_CYCLES(4), .DEPTH(8)) dut (
        .Clk(Clk), .Rst(Rst), .StepTick(StepTick), .NumberA(NumberA),
        .NumberB(NumberB), .Prev(Prev), .Next(Next), .out7(out7),
        .en_out(en_out), .Offset(Offset), .Count(Count)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic st, input logic p, input logic n, input logic [31:0] b);
        StepTick = st;
        Prev = p;
        Next = n;
        if (st) NumberB = b;
        tick();
        StepTick = 1'b0;
        Prev = 1'b0;
        Next = 1'b0;
    endtask

    // Let the view settle, then wait (bounded) for a digit enable and check its glyph.
    task automatic show(input string tag, input logic [7:0] en_exp, input logic [6:0] seg_exp);
        tick();
        tick();
        for (int k = 0; k < 40 && en_out !== en_exp; k++) tick();
        chk({tag, "_en"}, en_out, en_exp);
        chk(tag, out7, seg_exp);
    endtask

    logic [7:0] en_tab [8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    // A=0xA1F8 on digits 0..3 (8,F,1,A), B=0 on digits 4..7
    logic [6:0] seg_tab [8] = '{7'b0000000, 7'b0001110, 7'b1111001, 7'b0001000,
                                7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

    initial begin
        tick();
        tick();
        chk("rst_en", en_out, 8'hFF);
        chk("rst_seg", out7, 7'h7F);
        chk("rst_off", Offset, 4'd0);
        chk("rst_cnt", Count, 4'd0);

        Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pre_en", en_out, 8'hFF);
            chk("pre_seg", out7, 7'h7F);
        end
        tick();
        chk("first_en", en_out, 8'hFE);
        chk("dig0_seg", out7, seg_tab[0]);
        for (int d = 1; d < 8; d++) begin
            repeat (4) tick();
            chk("scan_en", en_out, en_tab[d]);
            chk("scan_seg", out7, seg_tab[d]);
        end
        repeat (4) tick();
        chk("wrap_en", en_out, 8'hFE);

        // Three captures then two Prev: view PC 0x14 (live is 0x18 -> glyph 8)
        step(1'b1, 1'b0, 1'b0, 32'h10);
        step(1'b1, 1'b0, 1'b0, 32'h14);
        step(1'b1, 1'b0, 1'b0, 32'h18);
        chk("cap3_cnt", Count, HIST ? 4'd3 : 4'd0);
        chk("cap3_off", Offset, 4'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("prev1_off", Offset, HIST ? 4'd1 : 4'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("prev2_off", Offset, HIST ? 4'd2 : 4'd0);
        chk("prev2_cnt", Count, HIST ? 4'd3 : 4'd0);
        show("prev2_d4", 8'hEF, HIST ? 7'b0011001 : 7'b0000000);

        // Prev saturates at Count, Next saturates at live
        repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("prev5_off", Offset, HIST ? 4'd3 : 4'd0);
        show("off3_d4", 8'hEF, HIST ? 7'b1000000 : 7'b0000000);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("next1_off", Offset, HIST ? 4'd2 : 4'd0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("next4_off", Offset, 4'd0);
        show("live_d4", 8'hEF, 7'b0000000);

        // Prev+Next ignored; capture with Prev at Offset=1 gives 3
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0);
        chk("both_off", Offset, HIST ? 4'd1 : 4'd0);
        step(1'b1, 1'b1, 1'b0, 32'h1C);
        chk("capprev_off", Offset, HIST ? 4'd3 : 4'd0);
        chk("capprev_cnt", Count, HIST ? 4'd4 : 4'd0);
        show("capprev_d4", 8'hEF, HIST ? 7'b0011001 : 7'b1000110);

        // Fill to 8 entries, scroll to Offset=8, then capture twice more
        step(1'b1, 1'b0, 1'b0, 32'h20);
        step(1'b1, 1'b0, 1'b0, 32'h24);
        step(1'b1, 1'b0, 1'b0, 32'h28);
        step(1'b1, 1'b0, 1'b0, 32'h2C);
        chk("fill_cnt", Count, HIST ? 4'd8 : 4'd0);
        chk("fill_off", Offset, HIST ? 4'd7 : 4'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("off8", Offset, HIST ? 4'd8 : 4'd0);
        step(1'b1, 1'b0, 1'b0, 32'h30);
        chk("off8_cap1", Offset, HIST ? 4'd8 : 4'd0);
        step(1'b1, 1'b0, 1'b0, 32'h34);
        chk("off8_cap2", Offset, HIST ? 4'd8 : 4'd0);
        chk("off8_cnt", Count, HIST ? 4'd8 : 4'd0);
        show("off8_d4", 8'hEF, HIST ? 7'b0000000 : 7'b0011001);
        show("off8_d5", 8'hDF, HIST ? 7'b1111001 : 7'b0110000);

        // Reset in the middle of a scroll/capture
        StepTick = 1'b1;
        Prev = 1'b1;
        Rst = 1'b1;
        #2;
        chk("mid_rst_off", Offset, 4'd0);
        chk("mid_rst_cnt", Count, 4'd0);
        chk("mid_rst_en", en_out, 8'hFF);
        chk("mid_rst_seg", out7, 7'h7F);
        tick();
        chk("hold_rst_cnt", Count, 4'd0);
        StepTick = 1'b0;
        Prev = 1'b0;
        Rst = 1'b0;
        step(1'b1, 1'b1, 1'b0, 32'h40);
        chk("post_rst_cnt", Count, HIST ? 4'd1 : 4'd0);
        chk("post_rst_off", Offset, HIST ? 4'd1 : 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_display_scan.md
TRACE_DISPLAY_SCAN -- requirements
Module: trace_display_scan

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 100000, Clk cycles per digit in the scan.
REQ-002 SHALL have parameter DEPTH, fixed at 8, number of history entries.
REQ-003 SHALL have the port Clk  in  1  single clock for the whole block.
REQ-004 SHALL have the port Rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have the port StepTick  in  1  one-cycle pulse marking that a processor step completed.
REQ-006 SHALL have the port NumberA  in  32  ALU result to display and capture.
REQ-007 SHALL have the port NumberB  in  32  PC value to display and capture.
REQ-008 SHALL have the port Prev  in  1  one-cycle pulse that scrolls one entry back in the history.
REQ-009 SHALL have the port Next  in  1  one-cycle pulse that scrolls one entry forward, towards live.
REQ-010 SHALL have the port out7  out  7  active-low segments; bit6=g ... bit0=a.
REQ-011 SHALL have the port en_out  out  8  active-low digit enables.
REQ-012 SHALL have the port Offset  out  4  number of steps back being viewed; 0 means live.
REQ-013 SHALL have the port Count  out  4  number of valid history entries, 0..8.

Function
REQ-014 Capture: on a Clk edge with StepTick=1, SHALL write {NumberA,NumberB} to ring[WrPtr]; WrPtr SHALL advance modulo 8; Count SHALL increment, saturating at 8.
REQ-015 View source: when Offset=0, SHALL display NumberA/NumberB registered each cycle; when Offset=k>0, SHALL display ring[(WrPtr-k) mod 8].
REQ-016 Prev alone: Offset SHALL become min(Offset+1, Count); Next alone: Offset SHALL become max(Offset-1, 0); Prev=Next=1 SHALL be ignored.
REQ-017 A capture while Offset>0 SHALL increment Offset, so the same entry stays on screen; combined with Prev, Offset SHALL increase by 2; the result SHALL saturate at the updated Count (max 8).
REQ-018 At Offset=8 with a capture, the viewed entry is overwritten; Offset SHALL stay 8 and the display SHALL show the new oldest entry.
REQ-019 Scan divider SHALL count 0..REFRESH_CYCLES-1 and wrap; each wrap SHALL advance digit index 0..7, wrapping 7 to 0.
REQ-020 en_out SHALL equal ~(8'b1 << index) once scanning has started.
REQ-021 Digits 0-3 SHALL show NumberA view[15:0] and digits 4-7 SHALL show NumberB view[15:0]; digit 0 and digit 4 are the least significant nibbles.
REQ-022 Hex encoding (gfedcba, active-low) SHALL be: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110; the remaining values SHALL use standard hex glyphs.
REQ-023 out7 and en_out SHALL be registered; a change in the view source SHALL reach out7 within 2 Clk cycles while that digit is enabled.
REQ-024 Offset and Count SHALL be registered and SHALL update on the same edge as the event that causes the change.

Reset
REQ-025 Rst=1 SHALL immediately force WrPtr=0, Count=0, Offset=0, index=0, divider=0, en_out=8'hFF, out7=7'h7F, display registers=0.
REQ-026 Ring contents SHALL NOT require reset; entries at or beyond Count are never shown.
REQ-027 First digit enable (en_out=8'hFE) SHALL occur REFRESH_CYCLES cycles after Rst deasserts.
REQ-028 Rst asserted mid-scroll or mid-capture SHALL abandon the operation; no partial write SHALL be visible afterwards.

Configuration
REQ-029 Macro TRACE_HISTORY_EN defined: the ring buffer and Prev/Next scrolling SHALL be present as in REQ-014..018.
REQ-030 Macro TRACE_HISTORY_EN undefined: there SHALL be no ring storage; Prev/Next SHALL be ignored; Offset=0 and Count=0 permanently; the display SHALL always be live.

Verification
REQ-031 Bench SHALL use REFRESH_CYCLES=4 and cover the scenarios below.
REQ-032 Reset release -> en_out=FF for 4 cycles, then FE, FD, ..., 7F, FE in 4-cycle steps.
REQ-033 NumberA=0x0000_A1F8 live -> digits 0..3 out7 = 0000000, 0001110, 1111001, 0001000.
REQ-034 Capture PC=0x10,0x14,0x18, then Prev twice -> Offset=2, Count=3, digit 4 shows 4 (PC 0x14).
REQ-035 Prev x5 with Count=3 -> Offset=3; then Next x4 -> Offset=0 (live).
REQ-036 Offset=8 plus 2 further captures -> Offset stays 8, Count=8, display shows the entry captured 8 steps back.
REQ-037 Prev and Next together -> Offset unchanged; StepTick with Prev at Offset=1 -> Offset=3.
